// File: rtl/rr_mux_bus_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 WIDTH-bit bus. It registers a one-hot grant
// and the mux select, and forces rotation once a grant has carried MAX_BURST beats.
module rr_mux_bus_arbiter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic             S1,
    output logic             S0,
    output logic [WIDTH-1:0] f,
    output logic             out_valid,
    output logic [3:0]       beat_ack
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [SEL_W-1:0]   winner;
    logic               found;

    // First pending request, scanning upward from the rotation pointer.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[ptr + SEL_W'(k)]) begin
                found  = 1'b1;
                winner = ptr + SEL_W'(k);
            end
        end
    end

    // Next state, handshake and acknowledge; beats are suppressed while reset is held.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        out_valid = 1'b0;
        beat_ack  = '0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (found) begin
                    state_nxt = XFER;
                    sel_nxt   = winner;
                    gnt_nxt   = N_REQ'(1) << winner;
                    cnt_nxt   = '0;
                end
            end
            XFER: begin
                out_valid = req[sel] && rst_n;
                if (!req[sel]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = sel + SEL_W'(1);
                    gnt_nxt   = '0;
                end else if (out_valid && out_ready) begin
                    beat_ack = N_REQ'(1) << sel;
                    if (cnt == LAST_BEAT) begin
                        state_nxt = IDLE;
                        ptr_nxt   = sel + SEL_W'(1);
                        gnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign S1 = sel[1];
    assign S0 = sel[0];

    // Bus mux follows the registered select in every state.
    always_comb begin
        case (sel)
            2'd0:    f = I0;
            2'd1:    f = I1;
            2'd2:    f = I2;
            default: f = I3;
        endcase
    end

endmodule

// File: tb/tb_rr_mux_bus_arbiter.sv
// Directed bench for rr_mux_bus_arbiter: burst length, rotation, stall, withdraw,
// mid-burst reset, and a MAX_BURST=1 instance.
module tb_rr_mux_bus_arbiter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req, req1;
    logic [WIDTH-1:0] I0, I1, I2, I3;
    logic             out_ready, ready1;
    logic [3:0]       gnt, beat_ack, gnt1, beat_ack1;
    logic             S1, S0, S1_1, S0_1;
    logic [WIDTH-1:0] f, f1;
    logic             out_valid, out_valid1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_mux_bus_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .out_ready(out_ready), .gnt(gnt), .S1(S1), .S0(S0),
        .f(f), .out_valid(out_valid), .beat_ack(beat_ack)
    );

    rr_mux_bus_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .out_ready(ready1), .gnt(gnt1), .S1(S1_1), .S0(S0_1),
        .f(f1), .out_valid(out_valid1), .beat_ack(beat_ack1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        req1      = '0;
        out_ready = 1'b0;
        ready1    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0]       onehot;
    logic [WIDTH-1:0] idata [4];
    logic [3:0]       alt [4];

    initial begin
        I0 = 4'h1; I1 = 4'h5; I2 = 4'hA; I3 = 4'hC;
        idata[0] = 4'h1; idata[1] = 4'h5; idata[2] = 4'hA; idata[3] = 4'hC;
        alt[0] = 4'b0010; alt[1] = 4'b1000; alt[2] = 4'b0010; alt[3] = 4'b1000;

        // Reset values, sampled while reset is still asserted.
        rst_n = 1'b0; req = '0; req1 = '0; out_ready = 1'b0; ready1 = 1'b0;
        step();
        step();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", {S1, S0}, 2'b00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ack", beat_ack, 4'b0000);
        check("rst_f", f, 4'h1);
        rst_n = 1'b1;

        // Single requester 2: four beats, gap, re-grant.
        req = 4'b0100; out_ready = 1'b1; #1;
        check("t1_idle_gnt", gnt, 4'b0000);
        check("t1_idle_valid", out_valid, 1'b0);
        step();
        check("t1_gnt", gnt, 4'b0100);
        check("t1_sel", {S1, S0}, 2'b10);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("t1_ack%0d", b), beat_ack, 4'b0100);
            check($sformatf("t1_f%0d", b), f, 4'hA);
            check($sformatf("t1_valid%0d", b), out_valid, 1'b1);
            step();
        end
        check("t1_gap_gnt", gnt, 4'b0000);
        check("t1_gap_ack", beat_ack, 4'b0000);
        check("t1_gap_sel", {S1, S0}, 2'b10);
        step();
        check("t1_regrant", gnt, 4'b0100);

        // All four requesting: 0,1,2,3,0 with four beats each and an idle gap.
        do_reset();
        req = 4'b1111; out_ready = 1'b1; #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("t2_gap%0d", g), gnt, 4'b0000);
            step();
            onehot = 4'b0001 << g;
            for (int b = 0; b < 4; b++) begin
                check($sformatf("t2_gnt%0d_%0d", g, b), gnt, onehot);
                check($sformatf("t2_ack%0d_%0d", g, b), beat_ack, onehot);
                check($sformatf("t2_f%0d_%0d", g, b), f, idata[g]);
                step();
            end
        end
        check("t2_gap_wrap", gnt, 4'b0000);
        step();
        check("t2_wrap_gnt", gnt, 4'b0001);

        // Requester 1 stalled for three cycles after one beat.
        do_reset();
        req = 4'b0010; out_ready = 1'b1; #1;
        step();
        check("t3_ack_first", beat_ack, 4'b0010);
        step();
        out_ready = 1'b0; #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("t3_stall_ack%0d", s), beat_ack, 4'b0000);
            check($sformatf("t3_stall_valid%0d", s), out_valid, 1'b1);
            check($sformatf("t3_stall_gnt%0d", s), gnt, 4'b0010);
            check($sformatf("t3_stall_f%0d", s), f, 4'h5);
            step();
        end
        out_ready = 1'b1; #1;
        for (int b = 0; b < 3; b++) begin
            check($sformatf("t3_resume_ack%0d", b), beat_ack, 4'b0010);
            step();
        end
        check("t3_end_gnt", gnt, 4'b0000);

        // Requester 3 withdraws after two beats; pointer wraps to 0.
        do_reset();
        req = 4'b1000; out_ready = 1'b1; #1;
        step();
        check("t4_gnt", gnt, 4'b1000);
        check("t4_ack0", beat_ack, 4'b1000);
        step();
        check("t4_ack1", beat_ack, 4'b1000);
        step();
        req = 4'b0101; #1;
        check("t4_drop_valid", out_valid, 1'b0);
        check("t4_drop_ack", beat_ack, 4'b0000);
        step();
        check("t4_idle_gnt", gnt, 4'b0000);
        step();
        check("t4_next_gnt", gnt, 4'b0001);

        // Reset asserted after two beats of a burst.
        do_reset();
        req = 4'b0100; out_ready = 1'b1; #1;
        step();
        step();
        step();
        check("t5_pre_gnt", gnt, 4'b0100);
        rst_n = 1'b0; #1;
        check("t5_rst_ack", beat_ack, 4'b0000);
        step();
        check("t5_rst_gnt", gnt, 4'b0000);
        check("t5_rst_sel", {S1, S0}, 2'b00);
        check("t5_rst_valid", out_valid, 1'b0);
        rst_n = 1'b1; req = 4'b1010; #1;
        step();
        check("t5_after_gnt", gnt, 4'b0010);

        // MAX_BURST = 1: grants alternate 1,3,1,3 with one ack each.
        do_reset();
        req1 = 4'b1010; ready1 = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_gap%0d", k), gnt1, 4'b0000);
            step();
            check($sformatf("t6_gnt%0d", k), gnt1, alt[k]);
            check($sformatf("t6_ack%0d", k), beat_ack1, alt[k]);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
